// File: rtl/rsqrt_pipe_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsqrt_pkg
// Brief    : Shared widths, latency default and clog2 helper for the
//            rsqrt pipe arbiter slice.
// Revision : 1.0  initial release
// ============================================================================
package rsqrt_pkg;

    localparam int RSQRT_N_REQ  = 4;
    localparam int RSQRT_WL     = 24;
    localparam int RSQRT_WLO    = 24;
    localparam int RSQRT_DP_LAT = 6;

    // Tag entry {v, id, err}; id width is derived from the requester count.
    localparam int TAG_V_W   = 1;
    localparam int TAG_ERR_W = 1;

    function automatic int rsqrt_clog2(input int n);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= n) return r;
        end
        return 31;
    endfunction

    function automatic int rsqrt_tag_w(input int id_w);
        return TAG_V_W + id_w + TAG_ERR_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsqrt_pipe_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rsqrt_pipe_arbiter_if
// Brief    : Requester handshake, datapath and response bundle.
// Revision : 1.0  initial release
// ============================================================================
interface rsqrt_pipe_arbiter_if
    import rsqrt_pkg::*;
#(
    parameter int N_REQ = RSQRT_N_REQ,
    parameter int WL    = RSQRT_WL,
    parameter int WLO   = RSQRT_WLO
);
    logic                  en;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*WL-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  dp_ce;
    logic [WL-1:0]         dp_din;
    logic [WLO-1:0]        dp_dout;
    logic [N_REQ-1:0]      rsp_valid;
    logic [WLO-1:0]        rsp_data;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output en, req_valid, req_data, dp_dout,
        input  req_ready, dp_ce, dp_din, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  en, req_valid, req_data, dp_dout,
        output req_ready, dp_ce, dp_din, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/rsqrt_pipe_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin one-hot grant with pointer advancing past the winner.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import rsqrt_pkg::*;
#(
    parameter int N    = RSQRT_N_REQ,
    parameter int ID_W = rsqrt_clog2(N)
) (
    input  wire logic            CLK,
    input  wire logic            nRST,
    input  wire logic            en,
    input  wire logic [N-1:0]    req,
    output logic      [N-1:0]    grant,
    output logic      [ID_W-1:0] grant_id,
    output logic                 grant_valid
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_id;
    logic            w_found;

    always_comb begin
        w_found = 1'b0;
        w_id    = '0;
        w_sel   = '0;
        for (int i = 0; i < N; i++) begin
            w_sel = (int'(r_ptr) + i >= N) ? ID_W'(int'(r_ptr) + i - N)
                                           : ID_W'(int'(r_ptr) + i);
            if (en && !w_found && req[w_sel]) begin
                w_found = 1'b1;
                w_id    = w_sel;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (w_found) grant[w_id] = 1'b1;
    end

    assign grant_id    = w_id;
    assign grant_valid = w_found;

    // Grant only exists when the winner is valid, so grant_valid is the handshake.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_id) == N - 1) ? '0 : w_id + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsqrt_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rsqrt_pipe_arbiter
// Brief    : Shares a fixed-latency rsqrt datapath among N_REQ requesters.
//            Optional operand range check: RSQRT_ARB_RANGE_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module rsqrt_pipe_arbiter
    import rsqrt_pkg::*;
#(
    parameter int N_REQ  = RSQRT_N_REQ,
    parameter int WL     = RSQRT_WL,
    parameter int WLO    = RSQRT_WLO,
    parameter int DP_LAT = RSQRT_DP_LAT
) (
    input wire logic            CLK,
    input wire logic            nRST,
    rsqrt_pipe_arbiter_if.slave bus
);

    localparam int ID_W = rsqrt_clog2(N_REQ);

    logic                 w_en;
    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_gid;
    logic                 w_hs;
    logic [WL-1:0]        w_din;

    logic [DP_LAT-1:0]    r_tag_v;
    logic [ID_W-1:0]      r_tag_id [DP_LAT];
    logic [N_REQ-1:0]     r_rsp_valid;
    logic [WLO-1:0]       r_rsp_data;

    // Gating with nRST keeps req_ready low while reset is asserted.
    assign w_en = bus.en & nRST;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .CLK         (CLK),
        .nRST        (nRST),
        .en          (w_en),
        .req         (bus.req_valid),
        .grant       (w_grant),
        .grant_id    (w_gid),
        .grant_valid (w_hs)
    );

    always_comb begin
        w_din = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_din = bus.req_data[i*WL +: WL];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tag_v <= '0;
            for (int s = 0; s < DP_LAT; s++) r_tag_id[s] <= '0;
        end else begin
            r_tag_v     <= {r_tag_v[DP_LAT-2:0], w_hs};
            r_tag_id[0] <= w_gid;
            for (int s = 1; s < DP_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
        end
    end

`ifdef RSQRT_ARB_RANGE_CHECK_EN
    logic [DP_LAT-1:0] r_tag_err;
    logic              r_rsp_err;
    logic              w_err;

    assign w_err = w_hs & ~w_din[WL-1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_tag_err <= '0;
        else       r_tag_err <= {r_tag_err[DP_LAT-2:0], w_err};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_tag_v[DP_LAT-1]) begin
            r_rsp_valid <= '0;
            r_rsp_valid[r_tag_id[DP_LAT-1]] <= 1'b1;
            r_rsp_data  <= r_tag_err[DP_LAT-1] ? {WLO{1'b1}} : bus.dp_dout;
            r_rsp_err   <= r_tag_err[DP_LAT-1];
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (r_tag_v[DP_LAT-1]) begin
            r_rsp_valid <= '0;
            r_rsp_valid[r_tag_id[DP_LAT-1]] <= 1'b1;
            r_rsp_data  <= bus.dp_dout;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = w_grant;
    assign bus.dp_din    = w_din;
    assign bus.dp_ce     = nRST;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (|r_tag_v) | (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsqrt_pipe_arbiter
// Brief    : Directed bench for rsqrt_pipe_arbiter with a pure-delay datapath.
// Revision : 1.0  initial release
// ============================================================================
module tb_rsqrt_pipe_arbiter;

    localparam int N   = 4;
    localparam int WL  = 24;
    localparam int WLO = 24;
    localparam int LAT = 6;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_pass   = 0;
    int   n_checks = 0;

    rsqrt_pipe_arbiter_if #(.N_REQ(N), .WL(WL), .WLO(WLO)) bus_if ();

    rsqrt_pipe_arbiter #(
        .N_REQ  (N),
        .WL     (WL),
        .WLO    (WLO),
        .DP_LAT (LAT)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if)
    );

    always #5 CLK = ~CLK;

    logic [WL-1:0] r_dl [LAT];
    always @(posedge CLK) begin
        r_dl[0] <= bus_if.dp_din;
        for (int s = 1; s < LAT; s++) r_dl[s] <= r_dl[s-1];
    end
    assign bus_if.dp_dout = r_dl[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus_if.en        = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        #12;
        chk("rst_ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(bus_if.rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'h0);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_dp_ce", 32'(bus_if.dp_ce), 32'h0);
        next_cyc();
        nRST = 1'b1;
        bus_if.en = 1'b1;
        settle();
        chk("run_dp_ce", 32'(bus_if.dp_ce), 32'h1);

        // Single request from requester 0
        next_cyc();
        bus_if.req_data[0*WL +: WL] = 24'h800000;
        bus_if.req_valid = 4'b0001;
        settle();
        chk("t1_ready", 32'(bus_if.req_ready), 32'h1);
        chk("t1_dp_din", 32'(bus_if.dp_din), 32'h800000);
        for (int w = 1; w <= 8; w++) begin
            next_cyc();
            bus_if.req_valid = '0;
            settle();
            if (w == 1) chk("t1_busy", 32'(bus_if.busy), 32'h1);
            if (w < 7) chk("t1_no_early_rsp", 32'(bus_if.rsp_valid), 32'h0);
            if (w == 7) begin
                chk("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
                chk("t1_rsp_data", 32'(bus_if.rsp_data), 32'h800000);
                chk("t1_rsp_err", 32'(bus_if.rsp_err), 32'h0);
            end
            if (w == 8) begin
                chk("t1_rsp_pulse", 32'(bus_if.rsp_valid), 32'h0);
                chk("t1_idle", 32'(bus_if.busy), 32'h0);
            end
        end

        // Requester 2 waits while en is low
        for (int w = 0; w <= 12; w++) begin
            next_cyc();
            bus_if.req_data[2*WL +: WL] = 24'hA12345;
            bus_if.req_valid = (w <= 5) ? 4'b0100 : 4'b0000;
            bus_if.en = (w >= 5);
            settle();
            if (w < 5) chk("t3_no_ready", 32'(bus_if.req_ready), 32'h0);
            if (w == 5) begin
                chk("t3_ready", 32'(bus_if.req_ready), 32'h4);
                chk("t3_dp_din", 32'(bus_if.dp_din), 32'hA12345);
            end
            if (w == 11) chk("t3_no_early_rsp", 32'(bus_if.rsp_valid), 32'h0);
            if (w == 12) begin
                chk("t3_rsp_valid", 32'(bus_if.rsp_valid), 32'h4);
                chk("t3_rsp_data", 32'(bus_if.rsp_data), 32'hA12345);
            end
        end
        next_cyc();

        // Out-of-range operand on requester 1
        for (int w = 0; w <= 8; w++) begin
            next_cyc();
            bus_if.req_data[1*WL +: WL] = 24'h400000;
            bus_if.req_valid = (w == 0) ? 4'b0010 : 4'b0000;
            settle();
            if (w == 0) chk("t5_ready", 32'(bus_if.req_ready), 32'h2);
            if (w == 7) begin
                chk("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'h2);
`ifdef RSQRT_ARB_RANGE_CHECK_EN
                chk("t5_rsp_err", 32'(bus_if.rsp_err), 32'h1);
                chk("t5_rsp_data", 32'(bus_if.rsp_data), 32'hFFFFFF);
`else
                chk("t5_rsp_err", 32'(bus_if.rsp_err), 32'h0);
                chk("t5_rsp_data", 32'(bus_if.rsp_data), 32'h400000);
`endif
            end
        end

        // Requester 3 back-to-back, en toggling every cycle
        for (int w = 0; w <= 15; w++) begin
            next_cyc();
            bus_if.req_data[3*WL +: WL] = 24'hD00000 | 24'(w);
            bus_if.req_valid = (w < 8) ? 4'b1000 : 4'b0000;
            bus_if.en = (w % 2 == 0);
            settle();
            if (w < 8) chk("t6_ready", 32'(bus_if.req_ready), (w % 2 == 0) ? 32'h8 : 32'h0);
            chk("t6_busy", 32'(bus_if.busy), (w >= 1 && w <= 13) ? 32'h1 : 32'h0);
            if (w >= 7 && w <= 13 && (w % 2 == 1)) begin
                chk("t6_rsp_valid", 32'(bus_if.rsp_valid), 32'h8);
                chk("t6_rsp_data", 32'(bus_if.rsp_data), 32'hD00000 | 32'(w - 7));
            end else begin
                chk("t6_rsp_none", 32'(bus_if.rsp_valid), 32'h0);
            end
        end
        bus_if.en = 1'b1;

        // All four requesters continuously valid
        for (int i = 0; i < N; i++) bus_if.req_data[i*WL +: WL] = 24'hC00000 | 24'(i);
        for (int k = 0; k <= 20; k++) begin
            next_cyc();
            bus_if.req_valid = (k < 12) ? 4'b1111 : 4'b0000;
            settle();
            if (k < 12) begin
                chk("t2_ready", 32'(bus_if.req_ready), 32'h1 << (k % 4));
                chk("t2_dp_din", 32'(bus_if.dp_din), 32'hC00000 | 32'(k % 4));
            end
            if (k >= 7 && k < 19) begin
                chk("t2_rsp_valid", 32'(bus_if.rsp_valid), 32'h1 << ((k - 7) % 4));
                chk("t2_rsp_data", 32'(bus_if.rsp_data), 32'hC00000 | 32'((k - 7) % 4));
            end else begin
                chk("t2_rsp_none", 32'(bus_if.rsp_valid), 32'h0);
            end
        end

        // Reset while three ops are in flight
        bus_if.req_data[1*WL +: WL] = 24'h9ABCDE;
        for (int w = 0; w <= 12; w++) begin
            next_cyc();
            bus_if.req_valid = (w <= 2) ? 4'b0010 : (w == 3 || w == 4) ? 4'b1111 : 4'b0000;
            if (w == 3) nRST = 1'b0;
            if (w == 4) begin
                nRST = 1'b1;
                bus_if.req_data[0*WL +: WL] = 24'h8ABCDE;
            end
            settle();
            if (w == 0) chk("t4_ready", 32'(bus_if.req_ready), 32'h2);
            if (w == 3) begin
                chk("t4_rst_ready", 32'(bus_if.req_ready), 32'h0);
                chk("t4_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
                chk("t4_rst_rsp_data", 32'(bus_if.rsp_data), 32'h0);
                chk("t4_rst_busy", 32'(bus_if.busy), 32'h0);
                chk("t4_rst_dp_ce", 32'(bus_if.dp_ce), 32'h0);
            end
            if (w == 4) chk("t4_ptr_reset", 32'(bus_if.req_ready), 32'h1);
            if (w >= 5 && w <= 10) chk("t4_no_stale_rsp", 32'(bus_if.rsp_valid), 32'h0);
            if (w == 11) begin
                chk("t4_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
                chk("t4_rsp_data", 32'(bus_if.rsp_data), 32'h8ABCDE);
            end
            if (w == 12) chk("t4_idle", 32'(bus_if.busy), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
